// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the coalescing store buffer.
package store_buffer_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int IDX_W         = 30;
  localparam int DATA_W        = 32;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/store_buffer_cam.sv
// Combinational word-index match against every buffered entry.
// The result feeds both the coalesce path and the load-forwarding path.
module store_buffer_cam
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH*IDX_W-1:0]  index,
  input  logic [DEPTH*DATA_W-1:0] data,
  input  logic [IDX_W-1:0]        key,
  output logic                    hit,
  output logic [PW-1:0]           ptr,
  output logic [DATA_W-1:0]       hit_data
);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid[gi] && (index[gi*IDX_W +: IDX_W] == key);
    end
  endgenerate

  // Coalescing keeps at most one match, so a plain priority pick is exact.
  always_comb begin
    hit      = 1'b0;
    ptr      = '0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) begin
        hit      = 1'b1;
        ptr      = PW'(i);
        hit_data = data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Coalescing store buffer between the MEM stage and word-addressed data memory.
// Stores retire in one cycle; the head drains whenever the memory port is idle.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_mem_read,
  input  logic          cpu_mem_write,
  input  logic [31:0]   cpu_address,
  input  logic [31:0]   cpu_write_data,
  output logic [31:0]   cpu_read_data,
  input  logic          fence,
  output logic          stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_address,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_read_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        entries_reg [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;

  logic [DEPTH-1:0]        valid_flat;
  logic [DEPTH*IDX_W-1:0]  index_flat;
  logic [DEPTH*DATA_W-1:0] data_flat;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign valid_flat[gi]                    = entries_reg[gi].valid;
      assign index_flat[gi*IDX_W +: IDX_W]     = entries_reg[gi].index;
      assign data_flat[gi*DATA_W +: DATA_W]    = entries_reg[gi].data;
    end
  endgenerate

  logic [IDX_W-1:0]  word;
  logic              hit;
  logic [PW-1:0]     hit_ptr;
  logic [DATA_W-1:0] hit_data;

  assign word = cpu_address[31:2];

  store_buffer_cam #(.DEPTH(DEPTH), .PW(PW)) u_cam (
    .valid    (valid_flat),
    .index    (index_flat),
    .data     (data_flat),
    .key      (word),
    .hit      (hit),
    .ptr      (hit_ptr),
    .hit_data (hit_data)
  );

  logic full;
  logic fence_active;
  logic access;
  logic miss_full;
  logic drain;
  logic push;
  logic coalesce;

  assign full         = (count_reg == CW'(DEPTH));
  assign fence_active = fence && (count_reg != '0);
  assign access       = cpu_mem_read || cpu_mem_write;
  assign miss_full    = cpu_mem_write && !hit && full && !fence_active;
  // A fence owns the port; otherwise only an idle CPU or a full-miss frees it.
  assign drain        = (count_reg != '0) && (fence_active || !access || miss_full);
  assign push         = cpu_mem_write && !hit && !full && !fence_active;
  assign coalesce     = cpu_mem_write && hit && !fence_active;

  assign stall          = fence_active || miss_full;
  assign mem_read       = cpu_mem_read && !fence_active;
  assign mem_write      = drain;
  assign mem_address    = drain ? {entries_reg[head_reg].index, 2'b00} : cpu_address;
  assign mem_write_data = drain ? entries_reg[head_reg].data : '0;
  assign cpu_read_data  = !cpu_mem_read ? '0 : (hit ? hit_data : mem_read_data);
  assign count          = count_reg;
  assign empty          = (count_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i] <= '0;
      end
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      // Push and drain never coincide: a push is a CPU access on a non-full buffer.
      if (push) begin
        entries_reg[tail_reg] <= '{valid: 1'b1, index: word, data: cpu_write_data};
        tail_reg              <= tail_reg + 1'b1;
        count_reg             <= count_reg + 1'b1;
      end else if (drain) begin
        entries_reg[head_reg].valid <= 1'b0;
        head_reg                    <= head_reg + 1'b1;
        count_reg                   <= count_reg - 1'b1;
      end
      if (coalesce) begin
        entries_reg[hit_ptr].data <= cpu_write_data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a negedge-commit data memory model.
`timescale 1ns/1ps
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        cpu_mem_read;
  logic        cpu_mem_write;
  logic [31:0] cpu_address;
  logic [31:0] cpu_write_data;
  logic [31:0] cpu_read_data;
  logic        fence;
  logic        stall;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [2:0]  count;
  logic        empty;

  logic [31:0] tb_mem [64];
  int checks_total;
  int checks_passed;

  store_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_mem_read   (cpu_mem_read),
    .cpu_mem_write  (cpu_mem_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .fence          (fence),
    .stall          (stall),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .count          (count),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = tb_mem[mem_address[7:2]];

  always @(negedge clk) begin
    if (mem_write) tb_mem[mem_address[7:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one CPU request just after the edge, then leave time for combinational settling.
  task automatic cycle(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic fen);
    @(posedge clk);
    #1;
    cpu_mem_read   = rd;
    cpu_mem_write  = wr;
    cpu_address    = addr;
    cpu_write_data = wdata;
    fence          = fen;
    #2;
    $display("t=%0t rd=%0b wr=%0b addr=0x%0h wdata=0x%0h fence=%0b | stall=%0b mw=%0b ma=0x%0h md=0x%0h cnt=%0d",
             $time, rd, wr, addr, wdata, fen, stall, mem_write, mem_address, mem_write_data, count);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    checks_total   = 0;
    checks_passed  = 0;
    for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;
    tb_mem[9]      = 32'h0000_5A5A;
    rst_n          = 1'b1;
    cpu_mem_read   = 1'b0;
    cpu_mem_write  = 1'b0;
    cpu_address    = 32'h0;
    cpu_write_data = 32'h0;
    fence          = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    #10 rst_n = 1'b1;

    // Single store then idle drain.
    cycle(1'b0, 1'b1, 32'h10, 32'h11, 1'b0);
    check("t1_stall", 32'(stall), 32'd0);
    check("t1_no_mw", 32'(mem_write), 32'd0);
    idle();
    check("t1_count1", 32'(count), 32'd1);
    check("t1_mw", 32'(mem_write), 32'd1);
    check("t1_maddr", mem_address, 32'h10);
    check("t1_mdata", mem_write_data, 32'h11);
    idle();
    check("t1_count0", 32'(count), 32'd0);
    check("t1_mem4", tb_mem[4], 32'h11);

    // Forwarding and memory-sourced load.
    cycle(1'b0, 1'b1, 32'h20, 32'hAA, 1'b0);
    cycle(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("t2_fwd", cpu_read_data, 32'hAA);
    check("t2_fwd_mw", 32'(mem_write), 32'd0);
    check("t2_fwd_mr", 32'(mem_read), 32'd1);
    cycle(1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
    check("t2_memload", cpu_read_data, 32'h5A5A);
    check("t2_count", 32'(count), 32'd1);
    idle();
    check("t2_drain_addr", mem_address, 32'h20);
    idle();
    check("t2_mem8", tb_mem[8], 32'hAA);

    // Back-to-back stores to one word coalesce.
    cycle(1'b0, 1'b1, 32'h30, 32'h1, 1'b0);
    cycle(1'b0, 1'b1, 32'h30, 32'h2, 1'b0);
    check("t3_stall", 32'(stall), 32'd0);
    idle();
    check("t3_count", 32'(count), 32'd1);
    check("t3_mdata", mem_write_data, 32'h2);
    idle();
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_mem12", tb_mem[12], 32'h2);

    // Fill, then a missing store stalls while the head drains.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 32'hB0, 1'b0);
    check("t4_full_count", 32'(count), 32'd4);
    check("t4_stall", 32'(stall), 32'd1);
    check("t4_mw", 32'(mem_write), 32'd1);
    check("t4_maddr", mem_address, 32'h0);
    check("t4_mdata", mem_write_data, 32'hA0);
    cycle(1'b0, 1'b1, 32'h40, 32'hB0, 1'b0);
    check("t4_accept", 32'(stall), 32'd0);
    check("t4_count3", 32'(count), 32'd3);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t4_count4", 32'(count), 32'd4);
    begin : drain_all
      int budget;
      budget = 0;
      while (stall && budget < 10) begin
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        budget++;
      end
      check("t4_drain_budget", 32'(stall), 32'd0);
    end
    check("t4_mem0", tb_mem[0], 32'hA0);
    check("t4_mem3", tb_mem[3], 32'hA3);
    check("t4_mem16", tb_mem[16], 32'hB0);

    // Fence drains three entries in FIFO order.
    cycle(1'b0, 1'b1, 32'h50, 32'hC0, 1'b0);
    cycle(1'b0, 1'b1, 32'h54, 32'hC1, 1'b0);
    cycle(1'b0, 1'b1, 32'h58, 32'hC2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check("t5_stall", 32'(stall), 32'd1);
      check("t5_order", mem_address, 32'h50 + 32'(i * 4));
      check("t5_data", mem_write_data, 32'hC0 + 32'(i));
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t5_release", 32'(stall), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_no_mw", 32'(mem_write), 32'd0);
    check("t5_mem22", tb_mem[22], 32'hC2);

    // Asynchronous reset discards pending stores.
    cycle(1'b0, 1'b1, 32'h60, 32'hD0, 1'b0);
    cycle(1'b0, 1'b1, 32'h64, 32'hD1, 1'b0);
    @(posedge clk);
    #1;
    cpu_mem_write = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t6_count", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_no_mw_rst", 32'(mem_write), 32'd0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("t6_no_mw", 32'(mem_write), 32'd0);
    end
    check("t6_mem24", tb_mem[24], 32'h0);
    check("t6_mem25", tb_mem[25], 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer between the MEM pipeline stage and the word-addressed data memory.
- Stores from the MEM stage are absorbed into a small coalescing FIFO, so they complete in one cycle without occupying the memory port.
- Buffered stores drain to data memory on cycles when the CPU makes no memory access.
- Loads that hit a buffered address are forwarded from the buffer; all other loads read memory combinationally.

Parameters:
- DEPTH, 4, number of buffered store entries (power of two, >=2).
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_mem_read  in  1  MEM-stage load request.
- cpu_mem_write  in  1  MEM-stage store request; never asserted together with cpu_mem_read.
- cpu_address  in  32  byte address; word index is cpu_address[31:2].
- cpu_write_data  in  32  store data.
- cpu_read_data  out  32  load result; 0 when cpu_mem_read=0.
- fence  in  1  request to drain the buffer completely before proceeding.
- stall  out  1  pipeline hold; the current CPU request is not accepted this cycle.
- mem_read  out  1  to data memory read enable.
- mem_write  out  1  to data memory write enable; memory commits on negedge of the same cycle.
- mem_address  out  32  to data memory address.
- mem_write_data  out  32  to data memory write data.
- mem_read_data  in  32  from data memory, combinational read.
- count  out  CW  current number of valid entries.
- empty  out  1  count==0.

Behaviour:
- Storage:
  - Circular FIFO with head/tail pointers that wrap modulo DEPTH.
  - Each entry holds word index [29:0], data [31:0] and a valid bit.
  - At most one valid entry exists per word index; this invariant is maintained by coalescing.
- Reset (async, rst_n=0):
  - All valid bits cleared, pointers 0, count=0, empty=1.
  - Any pending stores are discarded.
  - With no CPU request: stall=0, mem_write=0, mem_read=0.
- Store with coalesce hit (valid entry with the same word index): overwrite that entry's data in place. No push, stall=0, count unchanged.
- Store with miss, count<DEPTH: push at tail, stall=0, count+1.
- Store with miss, count==DEPTH:
  - stall=1 and the store is not accepted.
  - The memory port drains the head this cycle and the head is popped at the clock edge.
  - The CPU re-presents the store next cycle, where it is accepted.
- Load:
  - mem_read=1, mem_address=cpu_address, stall=0.
  - cpu_read_data = data of the matching entry if one exists, else mem_read_data.
  - Forwarding is combinational, with zero extra latency.
- Drain:
  - Occurs when count>0 and (no CPU access this cycle, or a full-miss stall, or fence=1).
  - mem_write=1, mem_address={head index,2'b00}, mem_write_data=head data.
  - Head is popped at the posedge ending the cycle.
- Fence:
  - While fence=1 and count>0: stall=1, drain every cycle, CPU requests ignored.
  - stall deasserts combinationally in the cycle count reaches 0.
  - fence with empty buffer: stall=0.
- Port priority: the memory port is never used for a load and a drain in the same cycle. A load always wins unless fence=1.
- Drain of the head and coalesce into the head in the same cycle cannot happen: a coalescing store is a CPU access, so no drain occurs that cycle.
- Pointer wrap: tail==head with count==DEPTH means full; count disambiguates.
- mem_read and mem_write are never both 1.

Decomposition:
- Shared package: DEPTH default, word-index width (30), and the entry struct {valid, index, data}.
- One natural sub-module, store_buffer_cam: combinational match of a word index against all entries, returning hit, entry pointer and data.
- The shared match is used by both the coalesce and forwarding paths.

Test Plan:
- Store 0x11 to addr 0x10, then idle cycle -> count 1→0; mem_write=1 with mem_address=0x10 and mem_write_data=0x11 during the idle cycle; memory word 4 = 0x11.
- Store 0xAA to 0x20, then load 0x20 next cycle -> cpu_read_data=0xAA with mem_write=0 (forwarded); load 0x24 -> returns mem_read_data.
- Store 0x1 then 0x2 to 0x30 back-to-back -> count=1; after drain, memory word 12 = 0x2.
- Fill 4 distinct stores (0x0,0x4,0x8,0xC) with no idle, then store to 0x40 -> stall=1 for one cycle, 0x0 drained; store accepted next cycle, count=4.
- 3 buffered stores, fence=1 -> stall=1 for 3 cycles with drains in FIFO order, then stall=0, empty=1.
- 2 buffered stores, pull rst_n low mid-cycle -> count=0 and empty=1 immediately; no mem_write afterwards; memory unchanged.
